// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs and segment bit order.
// Bit order of every pattern: [6:0] = g,f,e,d,c,b,a and [7] = decimal point.
package seg_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Glyphs carry the dp bit high (off); the decoder overrides it.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [15:0][7:0] SEG_HEX = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    function automatic logic [7:0] seg_apply_dp(input logic [7:0] pat, input logic dp);
        logic [7:0] seg;
        seg             = pat;
        seg[SEG_DP_BIT] = ~dp;
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-low seven-segment pattern.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = seg_apply_dp(SEG_HEX[i_nibble], i_dp);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with guard gap and frame-synchronous data update.
// Optional build macro SEG_LZB_EN enables leading-zero blanking of digits above digit 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    output logic [7:0]            outLED,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_active_val;
    logic [DIGITS-1:0]   r_active_dp;
    logic                r_pending;
    logic [7:0]          r_led;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic                w_guard_done;
    logic                w_dark;
    logic                w_lzb;
    logic [3:0]          w_cur_nib;
    logic                w_cur_dp;
    logic [7:0]          w_seg;
    logic [DIGITS-1:0]   w_an_sel;

    genvar gi;

    assign w_tick = (r_cnt == CNT_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing on the wrap tick bypasses the shadow so it shows next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_wrap && load) begin
                r_active_val <= value;
                r_active_dp  <= dp_in;
            end else if (w_wrap && r_pending) begin
                r_active_val <= r_shadow_val;
                r_active_dp  <= r_shadow_dp;
            end
            if (load) begin
                r_pending <= !w_wrap;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard_done = 1'b1;
        end else begin : g_guard
            localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
            assign w_guard_done = (r_cnt >= GUARD_C);
        end
    endgenerate

    assign w_dark    = blank || !w_guard_done;
    assign w_cur_nib = r_active_val[{r_idx, 2'b00} +: 4];
    assign w_cur_dp  = r_active_dp[r_idx];

    seg7_hex_decode u_decode (
        .i_nibble (w_cur_nib),
        .i_dp     (w_cur_dp),
        .o_seg    (w_seg)
    );

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_an_sel
            assign w_an_sel[gi] = (r_idx == IW'(gi));
        end
    endgenerate

`ifdef SEG_LZB_EN
    // w_hi_zero[k]: nibble k and every nibble above it are zero.
    logic [DIGITS-1:0] w_hi_zero;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign w_hi_zero[gi] = (r_active_val[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate
    assign w_lzb = (r_idx != '0) && w_hi_zero[r_idx];
`else
    assign w_lzb = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led        <= SEG_OFF;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_dark) begin
                r_led <= SEG_OFF;
                r_an  <= '1;
            end else begin
                r_led <= w_lzb ? {w_seg[SEG_DP_BIT], 7'h7F} : w_seg;
                r_an  <= ~w_an_sel;
            end
        end
    end

    assign outLED     = r_led;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver: successor to the single-digit combinational `LED` decoder. It holds DIGITS hex nibbles plus decimal points, scans one digit per refresh slot, inserts an anti-ghosting guard gap, and applies new display data only at frame boundaries so the display never tears. It sits between any value-producing logic and the board's common-anode seven-segment bank.

## Interface
- DIGITS, 4: number of digits scanned, 1..8.
- PRESCALE, 50000: clk cycles per digit slot, ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off, 0 ≤ GUARD < PRESCALE.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures value/dp_in into shadow.
- value  in  4*DIGITS  nibble k = digit k (digit 0 rightmost).
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank  in  1  level; 1 forces all anodes off.
- outLED  out  8  active-low segments; [6:0] = g..a, [7] = dp.
- an  out  DIGITS  active-low anode enables.
- frame_done  out  1  one-cycle pulse at end of last slot.
- pending  out  1  shadow holds data not yet displayed.

## Operation
- State: prescale count c (0..PRESCALE-1), digit index i (0..DIGITS-1), shadow regs, active regs, pending flag.
- c increments every cycle; at c = PRESCALE-1 ("tick"), c → 0 and i → i+1, wrapping DIGITS-1 → 0 ("wrap").
- load = 1: shadow ← {value, dp_in}, pending ← 1. Repeated loads before a wrap: last one wins.
- On wrap with pending = 1: active ← shadow, pending ← 0.
- load coinciding with wrap: active ← new value/dp_in directly (bypass), pending stays 0.
- Decode: hex 0–F, standard patterns (0 = 8'hC0 incl. dp off, F = 8'h8E); dp bit = ~dp.
- an[k] = 0 iff k == i, c ≥ GUARD and blank = 0; otherwise all ones. outLED = 8'hFF whenever all anodes are off.
- frame_done = 1 for the cycle after the wrap tick.

## Timing
- Reset (async assert): c = 0, i = 0, shadow = active = 0, pending = 0, outLED = 8'hFF, an = all ones, frame_done = 0.
- outLED, an and frame_done are registered: they reflect the state (c, i, active, blank) of the previous cycle.
- Load-to-display latency: from the load edge to the next wrap, at most DIGITS*PRESCALE cycles, plus 1 output register cycle plus GUARD before digit 0 lights.
- blank takes effect on outputs 1 cycle after it is sampled. The scan counters keep running while blank = 1.
- Reset mid-frame: everything returns to reset values immediately; pending data is discarded.
- DIGITS = 1: every tick is a wrap.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. Digit k > 0 shows segments off (outLED[6:0] = 7'h7F) if it and all higher active nibbles are 0. The dp still follows dp_in. The anode is still driven. Digit 0 is never blanked.
- SEG_LZB_EN undefined: all digits are always decoded. Logic is absent.

## Structure
- Shared package seg_pkg: segment pattern constants for 0–F, SEG_OFF = 8'hFF, and the segment bit-order definition.
- One sub-module, seg7_hex_decode: combinational nibble+dp → 8-bit active-low pattern, reused from the scan path.

## Test plan
Bench parameters: DIGITS = 4, PRESCALE = 8, GUARD = 2.
- Reset release, no load → outLED = 8'hC0 on each slot after guard; an cycles 1110, 1101, 1011, 0111; frame_done every 32 cycles.
- load value = 16'h12AF, dp_in = 4'b0010 mid-frame → pending = 1 until wrap; the next frame shows digit0 = 8'h8E and digit1 = 8'h08 (A with dp lit).
- Two loads in one frame (16'h1111, then 16'h2222) → only 2222 is ever displayed; 1111 never appears.
- load asserted on the wrap-tick cycle with 16'h3333 → shown in the immediately following frame; pending never rises.
- Assert blank for 10 cycles → an = 4'hF and outLED = 8'hFF from 1 cycle after assertion until 1 cycle after release; scan phase unaffected.
- SEG_LZB_EN, value = 16'h0050 → digits 3 and 2 show 8'hFF segments with their anodes still driven, digit 1 shows 5, digit 0 shows 0. rst_n pulsed mid-slot → all outputs at reset values asynchronously.
